// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the pipelined core: tracks in-flight
// destinations, raises load-use stalls, sequences redirect flushes and counts stalls.
module pipeline_hazard_unit #(
    parameter int STAGES      = 3,
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_STAGE  = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16,
    parameter int FW_W        = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  redirect_i,
    output logic                  stall_o,
    output logic                  bubble_o,
    output logic                  flush_o,
    output logic [FW_W-1:0]       fwd_a_o,
    output logic [FW_W-1:0]       fwd_b_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int FC_W = $clog2(FLUSH_DEPTH) + 1;
    localparam logic [FC_W-1:0]       FC_ZERO      = {FC_W{1'b0}};
    localparam logic [FC_W-1:0]       FC_ONE       = FC_W'(1);
    localparam logic [FC_W-1:0]       FLUSH_RELOAD = FC_W'(FLUSH_DEPTH - 2);
    localparam logic [FW_W-1:0]       FW_ZERO      = {FW_W{1'b0}};
    localparam logic [FW_W-1:0]       FW_ONE       = FW_W'(1);
    localparam logic [FW_W-1:0]       LAST_IDX     = FW_W'(STAGES - 1);
    localparam logic [FW_W-1:0]       LOAD_IDX     = FW_W'(LOAD_STAGE);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG     = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX      = {CNT_W{1'b1}};

    typedef struct packed {
        logic            hit;
        logic [FW_W-1:0] idx;
        logic            is_load;
    } match_t;

    // Scoreboard: index 0 is EX, index STAGES-1 is WB.
    logic [STAGES-1:0]                 valid_q, valid_d;
    logic [STAGES-1:0]                 load_q,  load_d;
    logic [STAGES-1:0][REG_ADDR_W-1:0] rd_q,    rd_d;
    logic [FC_W-1:0]                   flush_cnt_q, flush_cnt_d;
    logic [FW_W-1:0]                   fwd_a_q, fwd_a_d;
    logic [FW_W-1:0]                   fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]                  stall_cnt_q, stall_cnt_d;

    match_t match_a_s, match_b_s;
    logic   hazard_s, flush_active_s, stall_s, bubble_s, flush_s, enter_s;

    // Walk from the oldest entry to the youngest so the youngest match overwrites.
    function automatic match_t find_match(
        input logic [REG_ADDR_W-1:0]             rs,
        input logic                              used,
        input logic [STAGES-1:0]                 vld,
        input logic [STAGES-1:0][REG_ADDR_W-1:0] rds,
        input logic [STAGES-1:0]                 lds
    );
        match_t res;
        logic   hit_k;
        res.hit     = 1'b0;
        res.idx     = FW_ZERO;
        res.is_load = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hit_k       = used && (rs != ZERO_REG) && vld[k] && (rds[k] == rs);
            res.hit     = hit_k ? 1'b1       : res.hit;
            res.idx     = hit_k ? FW_W'(k)   : res.idx;
            res.is_load = hit_k ? lds[k]     : res.is_load;
        end
        return res;
    endfunction

    // A WB-stage match reaches ID through the register-file write-through path.
    function automatic logic [FW_W-1:0] fwd_sel(input match_t m);
        return (m.hit && (m.idx != LAST_IDX)) ? (m.idx + FW_ONE) : FW_ZERO;
    endfunction

    // Hazard detection and the combinational pipeline controls.
    always_comb begin
        match_a_s      = find_match(id_rs1_i, id_rs1_used_i, valid_q, rd_q, load_q);
        match_b_s      = find_match(id_rs2_i, id_rs2_used_i, valid_q, rd_q, load_q);
        hazard_s       = (match_a_s.hit && match_a_s.is_load && (match_a_s.idx < LOAD_IDX)) ||
                         (match_b_s.hit && match_b_s.is_load && (match_b_s.idx < LOAD_IDX));
        flush_active_s = (flush_cnt_q != FC_ZERO);
        stall_s        = reset && hazard_s && !redirect_i;
        bubble_s       = stall_s || (reset && redirect_i);
        flush_s        = reset && (redirect_i || flush_active_s);
        enter_s        = id_valid_i && !stall_s && !bubble_s && !flush_active_s;
    end

    // Next-state for scoreboard, forwarding selects and counters.
    always_comb begin
        valid_d = {valid_q[STAGES-2:0], enter_s && id_reg_write_i && (id_rd_i != ZERO_REG)};
        load_d  = {load_q[STAGES-2:0], enter_s && id_mem_read_i};
        rd_d    = {rd_q[STAGES-2:0], enter_s ? id_rd_i : ZERO_REG};
        fwd_a_d = bubble_s ? FW_ZERO : fwd_sel(match_a_s);
        fwd_b_d = bubble_s ? FW_ZERO : fwd_sel(match_b_s);
        if (redirect_i) begin
            flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_active_s) begin
            flush_cnt_d = flush_cnt_q - FC_ONE;
        end else begin
            flush_cnt_d = FC_ZERO;
        end
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= {STAGES{1'b0}};
            load_q      <= {STAGES{1'b0}};
            rd_q        <= {(STAGES*REG_ADDR_W){1'b0}};
            flush_cnt_q <= FC_ZERO;
            fwd_a_q     <= FW_ZERO;
            fwd_b_q     <= FW_ZERO;
            stall_cnt_q <= CNT_ZERO;
        end else begin
            valid_q     <= valid_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_o     = stall_s;
    assign bubble_o    = bubble_s;
    assign flush_o     = flush_s;
    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined RISC-V core.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB phase registers.
- Keeps a scoreboard of in-flight destination registers, one entry per post-ID stage.
- Generates forwarding selects, load-use stalls with bubble insertion, multi-cycle front-end flush on redirect, and a saturating stall-cycle counter.

Parameters:
- STAGES, 3: scoreboard depth from EX to WB. entry[0]=EX, entry[STAGES-1]=WB. Legal range 2..7.
- REG_ADDR_W, 5: register address width.
- LOAD_STAGE, 1: index of the entry at whose end load data becomes forwardable (1=MEM). Must be less than STAGES.
- FLUSH_DEPTH, 2: number of younger instructions killed on redirect, counting ID. Must be at least 2.
- CNT_W, 16: width of the stall counter.
- Derived: FW_W = clog2(STAGES).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i  in  REG_ADDR_W  ID source 1.
- id_rs2_i  in  REG_ADDR_W  ID source 2.
- id_rs1_used_i  in  1  rs1 is actually read.
- id_rs2_used_i  in  1  rs2 is actually read.
- id_rd_i  in  REG_ADDR_W  ID destination.
- id_reg_write_i  in  1  ID instruction writes rd.
- id_mem_read_i  in  1  ID instruction is a load.
- redirect_i  in  1  taken branch/JAL/JALR resolved in EX this cycle.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  write NOP (all controls 0) into ID/EX.
- flush_o  out  1  invalidate IF/ID.
- fwd_a_o  out  FW_W  registered operand-A select for the EX instruction: 0=ID/EX register data, j=result held in entry[j].
- fwd_b_o  out  FW_W  same, for operand B.
- stall_cnt_o  out  CNT_W  count of load-use stall cycles, saturating.

Behaviour:
- Reset (reset=0, async): all entries invalid, flush counter 0, fwd_a_o=fwd_b_o=0, stall_cnt_o=0. Combinational outputs stall_o, bubble_o and flush_o evaluate to 0.
- Scoreboard entry fields: {valid, rd, is_load}.
  - Each clock: entry[k] <= entry[k-1] for k>=1.
  - entry[0] <= {id_reg_write_i & rd!=0, id_rd_i, id_mem_read_i} when id_valid_i & !stall_o & !bubble_o & !flush_active; otherwise entry[0] is invalid.
- Match rule for rsX (X=1,2): rsX_used & rsX!=0 & entry[k].valid & entry[k].rd==rsX. The youngest match (smallest k) wins; older matches are ignored.
- Load-use stall: stall_o=1 and bubble_o=1 when the winning match is a load at k<LOAD_STAGE, and redirect_i=0.
  - Defaults: a load in EX gives exactly 1 stall cycle.
  - Stall repeats each cycle until the condition clears.
- Forwarding: evaluated in ID, registered when ID advances.
  - Winning match at k<STAGES-1: fwd <= k+1.
  - Winning match at k=STAGES-1, or no match: fwd <= 0. The WB write is visible to same-cycle ID reads via the datapath's register-file write-through path.
  - While stall_o or bubble_o is asserted, fwd <= 0, because the bubble occupies EX.
- Redirect:
  - In the redirect cycle: bubble_o=1 and flush_o=1, and the ID instruction is not entered.
  - flush counter <= FLUSH_DEPTH-2. flush_o stays 1 while the counter is nonzero; the counter decrements each cycle. flush_active = counter!=0.
  - Redirect has priority over stall: stall_o=0 in the redirect cycle.
  - A redirect while flush is active reloads the counter.
  - redirect_i=1 with entry[0] invalid is a datapath error; the unit still flushes.
- stall_cnt_o increments in every stall_o=1 cycle and holds at 2^CNT_W-1.
- Reset asserted mid-stall or mid-flush: all state clears immediately. The first cycle after release sees an empty scoreboard.
- Latency: stall_o, bubble_o and flush_o are combinational from same-cycle inputs. fwd_* lags one cycle and aligns with the EX stage.

Test Plan:
- add x5 followed immediately by add x6,x5,x1 -> no stall; fwd_a_o=1 in the consumer's EX cycle. With one independent instruction between them -> fwd_a_o=2.
- lw x5 followed immediately by add x6,x5,x5 -> stall_o=bubble_o=1 for exactly 1 cycle; then fwd_a_o=fwd_b_o=2; stall_cnt_o=1.
- Writes to x0 by a preceding instruction, consumer reads x0 -> no stall, fwd=0. Two older producers of x7 -> the youngest wins (fwd=1, not 2).
- redirect_i=1 while ID holds a dependent load consumer -> stall_o=0, bubble_o=1, flush_o=1 for 1 cycle (FLUSH_DEPTH=2). With FLUSH_DEPTH=4 -> flush_o held for 3 cycles; a repeated redirect in cycle 2 extends it.
- CNT_W=2 with 5 load-use stalls -> stall_cnt_o=3, held.
- reset low during a stall with 3 valid entries -> all outputs 0 immediately. After release, add x5,x5,x5 -> fwd=0.
